hazard_fwd_unit: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipelined RV32I core. It replaces the stall-only hazard logic in the core top. It keeps its own shadow scoreboard of the EX, MEM and WB stages and uses it to pick forwarded operands for the ID/EX register, to stall on load-use, and to flush the fetch and decode slots when EX resolves a jump. A `FWD_EN` mode switch selects full forwarding or the legacy stall-until-writeback behaviour. Saturating performance counters record stall and flush cycles.

---
 rtl/hazard_fwd_unit_if.sv | 50 +++++
 rtl/hazard_fwd_unit.sv | 179 +++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if: bundles the ID-stage source/destination description,
// the per-stage result buses and the hazard controller's decisions.
//   master : pipeline side (drives ID fields, results, jump_flag)
//   slave  : hazard/forwarding controller (drives stall, flushes,
//            forwarded operands and performance counters)
interface hazard_fwd_unit_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic              id_valid;
    logic [RA_W-1:0]   id_rs1_addr;
    logic [RA_W-1:0]   id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [RA_W-1:0]   id_rd_addr;
    logic              id_rf_wen;
    logic              id_is_load;
    logic [XLEN-1:0]   rf_rs1_data;
    logic [XLEN-1:0]   rf_rs2_data;
    logic [XLEN-1:0]   ex_result;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   wb_result;
    logic              jump_flag;
    logic              stall;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load,
               rf_rs1_data, rf_rs2_data, ex_result, mem_result, wb_result,
               jump_flag,
        input  stall, flush_if_id, flush_id_ex, rs1_fwd, rs2_fwd,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load,
               rf_rs1_data, rf_rs2_data, ex_result, mem_result, wb_result,
               jump_flag,
        output stall, flush_if_id, flush_id_ex, rs1_fwd, rs2_fwd,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard and operand-forwarding controller for a 5-stage
// RV32I pipeline. Tracks the writers in EX/MEM/WB in a shadow scoreboard,
// selects forwarded operands for ID/EX, stalls on load-use (or, with
// FWD_EN=0, on any in-flight writer), and flushes IF/ID + ID/EX on a jump.
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high
//   bus   : hazard_fwd_unit_if.slave (ID fields, stage results, jump_flag
//           in; stall, flush_if_id, flush_id_ex, rs1_fwd, rs2_fwd,
//           stall_cnt, flush_cnt out)
// stall, flushes and rs*_fwd are combinational; counters are registered.
module hazard_fwd_unit #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_unit_if.slave  bus
);

    // Load-ness only matters while the producer sits in EX: from MEM on
    // its data is on mem_result/wb_result, so later entries drop the flag.
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            rf_wen;
        logic            is_load;
    } ex_entry_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            rf_wen;
    } wr_entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RA_W-1:0]  REG_X0  = {RA_W{1'b0}};

    // A source depends on a stage entry only if that entry really writes
    // the same, non-x0 register and the ID instruction reads that source.
    function automatic logic src_match(input logic            valid,
                                       input logic [RA_W-1:0] rd,
                                       input logic            rf_wen,
                                       input logic [RA_W-1:0] src,
                                       input logic            used);
        return valid & rf_wen & (rd == src) & (src != REG_X0) & used;
    endfunction

    // Priority EX > MEM > WB > RF; a load in EX has no data yet.
    function automatic logic [XLEN-1:0] pick_operand(input logic            ex_hit,
                                                     input logic            ex_load,
                                                     input logic            mem_hit,
                                                     input logic            wb_hit,
                                                     input logic [XLEN-1:0] ex_data,
                                                     input logic [XLEN-1:0] mem_data,
                                                     input logic [XLEN-1:0] wb_data,
                                                     input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] sel;
        if (ex_hit && !ex_load) begin
            sel = ex_data;
        end else if (mem_hit) begin
            sel = mem_data;
        end else if (wb_hit) begin
            sel = wb_data;
        end else begin
            sel = rf_data;
        end
        return sel;
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit);
        logic [CNT_W-1:0] nxt;
        if (hit && (cnt != CNT_MAX)) begin
            nxt = cnt + CNT_W'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    ex_entry_t        ex_r;
    wr_entry_t        mem_r;
    wr_entry_t        wb_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic             rs1_ex_s, rs1_mem_s, rs1_wb_s;
    logic             rs2_ex_s, rs2_mem_s, rs2_wb_s;
    logic             raw_stall_s;
    logic             stall_s;
    logic             flush_s;
    logic [XLEN-1:0]  rs1_fwd_s;
    logic [XLEN-1:0]  rs2_fwd_s;

    // Per-source, per-stage dependency terms
    always_comb begin
        rs1_ex_s  = src_match(ex_r.valid,  ex_r.rd,  ex_r.rf_wen,  bus.id_rs1_addr, bus.id_rs1_used);
        rs1_mem_s = src_match(mem_r.valid, mem_r.rd, mem_r.rf_wen, bus.id_rs1_addr, bus.id_rs1_used);
        rs1_wb_s  = src_match(wb_r.valid,  wb_r.rd,  wb_r.rf_wen,  bus.id_rs1_addr, bus.id_rs1_used);
        rs2_ex_s  = src_match(ex_r.valid,  ex_r.rd,  ex_r.rf_wen,  bus.id_rs2_addr, bus.id_rs2_used);
        rs2_mem_s = src_match(mem_r.valid, mem_r.rd, mem_r.rf_wen, bus.id_rs2_addr, bus.id_rs2_used);
        rs2_wb_s  = src_match(wb_r.valid,  wb_r.rd,  wb_r.rf_wen,  bus.id_rs2_addr, bus.id_rs2_used);
    end

    // Stall/flush decision; a jump wins over any stall and reset masks both
    always_comb begin
        raw_stall_s = 1'b0;
        if (FWD_EN != 0) begin
            raw_stall_s = ex_r.is_load & (rs1_ex_s | rs2_ex_s);
        end else begin
            raw_stall_s = rs1_ex_s | rs1_mem_s | rs1_wb_s |
                          rs2_ex_s | rs2_mem_s | rs2_wb_s;
        end
        if (reset) begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end else begin
            flush_s = bus.jump_flag;
            stall_s = raw_stall_s & bus.id_valid & ~bus.jump_flag;
        end
    end

    // Operand selection for the ID/EX register
    always_comb begin
        if (reset || (FWD_EN == 0)) begin
            rs1_fwd_s = bus.rf_rs1_data;
            rs2_fwd_s = bus.rf_rs2_data;
        end else begin
            rs1_fwd_s = pick_operand(rs1_ex_s, ex_r.is_load, rs1_mem_s, rs1_wb_s,
                                     bus.ex_result, bus.mem_result, bus.wb_result,
                                     bus.rf_rs1_data);
            rs2_fwd_s = pick_operand(rs2_ex_s, ex_r.is_load, rs2_mem_s, rs2_wb_s,
                                     bus.ex_result, bus.mem_result, bus.wb_result,
                                     bus.rf_rs2_data);
        end
    end

    // Shadow scoreboard: advance one stage per clock, bubble on stall/jump
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            wb_r  <= mem_r;
            mem_r <= '{valid: ex_r.valid, rd: ex_r.rd, rf_wen: ex_r.rf_wen};
            if (bus.id_valid && !stall_s && !bus.jump_flag) begin
                ex_r <= '{valid: 1'b1, rd: bus.id_rd_addr,
                          rf_wen: bus.id_rf_wen, is_load: bus.id_is_load};
            end else begin
                ex_r <= '0;
            end
        end
    end

    // Saturating stall/flush cycle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_s);
        end
    end

    assign bus.stall       = stall_s;
    assign bus.flush_if_id = flush_s;
    assign bus.flush_id_ex = flush_s;
    assign bus.rs1_fwd     = rs1_fwd_s;
    assign bus.rs2_fwd     = rs2_fwd_s;
    assign bus.stall_cnt   = stall_cnt_r;
    assign bus.flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed bench for hazard_fwd_unit. Three instances:
//   dut_a : FWD_EN=1, CNT_W=16 (forwarding, load-use, x0, priority, jump, reset)
//   dut_b : FWD_EN=0, CNT_W=16 (stall-until-writeback)
//   dut_c : FWD_EN=0, CNT_W=4  (counter saturation)
module tb_hazard_fwd_unit;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_cmp;
    int   n_err;

    // {valid, rs1, rs1_used, rs2, rs2_used, rd, rf_wen, is_load}
    logic [19:0]  id_vec  [3];
    // {rf_rs1, rf_rs2, ex, mem, wb}
    logic [159:0] dat_vec [3];
    logic         jmp     [3];

    hazard_fwd_unit_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) ia ();
    hazard_fwd_unit_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) ib ();
    hazard_fwd_unit_if #(.XLEN(32), .RA_W(5), .CNT_W(4))  ic ();

    assign {ia.id_valid, ia.id_rs1_addr, ia.id_rs1_used, ia.id_rs2_addr, ia.id_rs2_used,
            ia.id_rd_addr, ia.id_rf_wen, ia.id_is_load} = id_vec[0];
    assign {ib.id_valid, ib.id_rs1_addr, ib.id_rs1_used, ib.id_rs2_addr, ib.id_rs2_used,
            ib.id_rd_addr, ib.id_rf_wen, ib.id_is_load} = id_vec[1];
    assign {ic.id_valid, ic.id_rs1_addr, ic.id_rs1_used, ic.id_rs2_addr, ic.id_rs2_used,
            ic.id_rd_addr, ic.id_rf_wen, ic.id_is_load} = id_vec[2];
    assign {ia.rf_rs1_data, ia.rf_rs2_data, ia.ex_result, ia.mem_result, ia.wb_result} = dat_vec[0];
    assign {ib.rf_rs1_data, ib.rf_rs2_data, ib.ex_result, ib.mem_result, ib.wb_result} = dat_vec[1];
    assign {ic.rf_rs1_data, ic.rf_rs2_data, ic.ex_result, ic.mem_result, ic.wb_result} = dat_vec[2];
    assign ia.jump_flag = jmp[0];
    assign ib.jump_flag = jmp[1];
    assign ic.jump_flag = jmp[2];

    hazard_fwd_unit #(.XLEN(32), .RA_W(5), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia));
    hazard_fwd_unit #(.XLEN(32), .RA_W(5), .FWD_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib));
    hazard_fwd_unit #(.XLEN(32), .RA_W(5), .FWD_EN(0), .CNT_W(4)) dut_c (
        .clk(clk), .reset(rst_c), .bus(ic));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] idw(input logic v, input logic [4:0] r1, input logic u1,
                                        input logic [4:0] r2, input logic u2,
                                        input logic [4:0] rd, input logic wen, input logic ld);
        return {v, r1, u1, r2, u2, rd, wen, ld};
    endfunction

    function automatic logic [159:0] dw(input logic [31:0] rf1, input logic [31:0] rf2,
                                        input logic [31:0] ex, input logic [31:0] mem,
                                        input logic [31:0] wb);
        return {rf1, rf2, ex, mem, wb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_vec[i]  = idw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            dat_vec[i] = dw(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
            jmp[i]     = 1'b0;
        end
        // reset: outputs masked even with a jump and a valid instruction
        id_vec[0]  = idw(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        dat_vec[0] = dw(32'h1111, 32'h2222, 32'h3333, 32'h4444, 32'h5555);
        jmp[0]     = 1'b1;
        mid();
        chk("rst_stall", ia.stall, 32'd0);
        chk("rst_flush_if_id", ia.flush_if_id, 32'd0);
        chk("rst_flush_id_ex", ia.flush_id_ex, 32'd0);
        chk("rst_rs1_fwd", ia.rs1_fwd, 32'h1111);
        chk("rst_rs2_fwd", ia.rs2_fwd, 32'h2222);
        nxt();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        jmp[0] = 1'b0;

        // back-to-back: addi x5,x0,7 ; add x6,x5,x5
        id_vec[0]  = idw(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        dat_vec[0] = dw(32'h0, 32'h0, 32'd7, 32'hAAAA, 32'hBBBB);
        mid();
        chk("rst_stall_cnt", ia.stall_cnt, 32'd0);
        chk("rst_flush_cnt", ia.flush_cnt, 32'd0);
        chk("addi_stall", ia.stall, 32'd0);
        nxt();
        id_vec[0] = idw(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        mid();
        chk("b2b_stall", ia.stall, 32'd0);
        chk("b2b_rs1_fwd", ia.rs1_fwd, 32'd7);
        chk("b2b_rs2_fwd", ia.rs2_fwd, 32'd7);
        nxt();
        id_vec[0] = idw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("b2b_stall_cnt", ia.stall_cnt, 32'd0);
        nxt();

        // load-use: lw x7,0(x1) ; add x8,x7,x0
        id_vec[0]  = idw(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        dat_vec[0] = dw(32'h10, 32'h0, 32'h1000, 32'h0, 32'h0);
        mid();
        chk("lw_stall", ia.stall, 32'd0);
        nxt();
        id_vec[0]  = idw(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        dat_vec[0] = dw(32'h5, 32'h0, 32'h1234, 32'h0, 32'h0);
        mid();
        chk("lu_stall", ia.stall, 32'd1);
        chk("lu_no_flush", ia.flush_if_id, 32'd0);
        nxt();
        dat_vec[0] = dw(32'h5, 32'h0, 32'h1234, 32'hDEADBEEF, 32'h9);
        mid();
        chk("lu_stall_once", ia.stall, 32'd0);
        chk("lu_rs1_mem", ia.rs1_fwd, 32'hDEADBEEF);
        chk("lu_rs2_x0", ia.rs2_fwd, 32'h0);
        chk("lu_stall_cnt", ia.stall_cnt, 32'd1);
        nxt();

        // x0: lw x0 then a reader of x0 -> no stall, RF data
        id_vec[0] = idw(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        nxt();
        id_vec[0]  = idw(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
        dat_vec[0] = dw(32'h55, 32'h66, 32'h99, 32'hAA, 32'hBB);
        mid();
        chk("x0_stall", ia.stall, 32'd0);
        chk("x0_rs1_rf", ia.rs1_fwd, 32'h55);
        chk("x0_rs2_rf", ia.rs2_fwd, 32'h66);
        nxt();

        // priority: two writers of x9, a bubble, then a reader of x9
        id_vec[0] = idw(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        nxt();
        nxt();
        id_vec[0] = idw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        nxt();
        id_vec[0]  = idw(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0);
        dat_vec[0] = dw(32'd4, 32'd0, 32'd3, 32'd1, 32'd2);
        mid();
        chk("prio_mem_over_wb", ia.rs1_fwd, 32'd1);
        chk("prio_stall", ia.stall, 32'd0);
        nxt();
        mid();
        chk("prio_wb_only", ia.rs1_fwd, 32'd2);
        nxt();
        mid();
        chk("prio_rf_fallback", ia.rs1_fwd, 32'd4);
        nxt();

        // reset in the middle of a load-use stall
        id_vec[0] = idw(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        nxt();
        id_vec[0]  = idw(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        dat_vec[0] = dw(32'h66, 32'h0, 32'h77, 32'h88, 32'h99);
        mid();
        chk("mid_stall_pre", ia.stall, 32'd1);
        chk("mid_stall_cnt_pre", ia.stall_cnt, 32'd1);
        rst_a = 1'b1;
        #1;
        chk("mid_stall_masked", ia.stall, 32'd0);
        chk("mid_rs1_rf", ia.rs1_fwd, 32'h66);
        nxt();
        rst_a = 1'b0;
        mid();
        chk("post_rst_stall", ia.stall, 32'd0);
        chk("post_rst_stall_cnt", ia.stall_cnt, 32'd0);
        chk("post_rst_flush_cnt", ia.flush_cnt, 32'd0);
        chk("post_rst_rs1", ia.rs1_fwd, 32'h66);
        nxt();

        // jump in the same cycle as a load-use match
        id_vec[0] = idw(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        nxt();
        id_vec[0] = idw(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        jmp[0]    = 1'b1;
        mid();
        chk("jmp_flush_if_id", ia.flush_if_id, 32'd1);
        chk("jmp_flush_id_ex", ia.flush_id_ex, 32'd1);
        chk("jmp_stall", ia.stall, 32'd0);
        nxt();
        jmp[0]     = 1'b0;
        id_vec[0]  = idw(1'b1, 5'd10, 1'b1, 5'd4, 1'b1, 5'd14, 1'b0, 1'b0);
        dat_vec[0] = dw(32'h66, 32'h44, 32'h77, 32'hCAFE, 32'h99);
        mid();
        chk("jmp_ex_bubble", ia.rs1_fwd, 32'h66);
        chk("jmp_load_in_mem", ia.rs2_fwd, 32'hCAFE);
        chk("jmp_flush_clear", ia.flush_if_id, 32'd0);
        chk("jmp_flush_cnt", ia.flush_cnt, 32'd1);
        chk("jmp_stall_cnt", ia.stall_cnt, 32'd0);
        nxt();
        id_vec[0] = idw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // stall-only mode: addi x5,x0,7 ; add x6,x5,x5
        id_vec[1]  = idw(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        dat_vec[1] = dw(32'h3333, 32'h4444, 32'd7, 32'hA, 32'hB);
        mid();
        chk("so_addi_stall", ib.stall, 32'd0);
        nxt();
        id_vec[1] = idw(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("so_stall", ib.stall, 32'd1);
            chk("so_rs1_rf", ib.rs1_fwd, 32'h3333);
            chk("so_rs2_rf", ib.rs2_fwd, 32'h4444);
            nxt();
        end
        mid();
        chk("so_release", ib.stall, 32'd0);
        chk("so_stall_cnt", ib.stall_cnt, 32'd3);
        chk("so_rs1_after", ib.rs1_fwd, 32'h3333);
        nxt();
        id_vec[1] = idw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // saturation with CNT_W=4: each writer/reader pair gives 3 stalls
        for (int k = 0; k < 4; k++) begin
            id_vec[2] = idw(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
            nxt();
            id_vec[2] = idw(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
            repeat (4) nxt();
        end
        mid();
        chk("sat_stall_cnt_12", ic.stall_cnt, 32'd12);
        for (int k = 0; k < 3; k++) begin
            id_vec[2] = idw(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
            nxt();
            id_vec[2] = idw(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
            repeat (4) nxt();
        end
        mid();
        chk("sat_stall_cnt_15", ic.stall_cnt, 32'd15);
        id_vec[2] = idw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        jmp[2]    = 1'b1;
        repeat (20) nxt();
        jmp[2] = 1'b0;
        mid();
        chk("sat_flush_cnt_15", ic.flush_cnt, 32'd15);
        chk("sat_stall_cnt_hold", ic.stall_cnt, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
